// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one fixed-latency LC-3 memory port between the CPU and a DMA requester.
module lc3_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdy,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_dma,
  output logic              busy
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              own_q, own_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              grant, pick_dma;
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant       = state_q == IDLE && (cpu_req || dma_req);
    pick_dma    = dma_req && (!cpu_req || starve_q == SW'(STARVE_MAX));
    // own_q is low in IDLE and during CPU accesses, so a waiting DMA keeps counting then
    starve_d    = (grant && pick_dma) ? '0 :
                  (dma_req && !own_q && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ISSUE;
        own_d   = pick_dma;
        we_d    = pick_dma ? dma_we : cpu_we;
        addr_d  = pick_dma ? dma_addr : cpu_addr;
        wdata_d = pick_dma ? dma_wdata : cpu_wdata;
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = LW'(1);
      end
      WAIT: if (lat_q == LW'(MEM_LAT)) begin
        state_d     = DONE;
        lat_d       = '0;
        cpu_rdata_d = (!we_q && !own_q) ? mem_rdata : cpu_rdata_q;
        dma_rdata_d = (!we_q && own_q) ? mem_rdata : dma_rdata_q;
      end else begin
        lat_d = lat_q + LW'(1);
      end
      default: begin
        state_d = IDLE;
        own_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      own_q       <= own_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end
  assign mem_en    = state_q == ISSUE;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_rdy   = state_q == DONE && !own_q;
  assign dma_rdy   = state_q == DONE && own_q;
  assign gnt_dma   = own_q;
  assign busy      = state_q != IDLE;
endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Shares the single LC-3 memory port between the CPU control FSM and a DMA/I-O requester. Each requester issues a request-and-hold access and receives a one-cycle ready pulse, which is the CPU's memRDY. The arbiter sequences each access over a fixed-latency memory and gives the CPU priority. A saturating starvation counter guarantees DMA progress. It sits between the datapath's MAR/MDR/memWE signals and the memory macro.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory read latency in cycles, >= 1
- STARVE_MAX, 8, DMA wait-cycle count that forces a DMA grant, >= 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_rdy
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_rdy  out  1  one-cycle completion pulse (memRDY)
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_rdy: same as the cpu_* ports, for the DMA port
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write, only asserted with mem_en
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- gnt_dma  out  1  1 while the current access belongs to DMA
- busy  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: evaluate requests each cycle and go to ISSUE on a grant.
  - Only CPU requesting: CPU wins.
  - Only DMA requesting: DMA wins.
  - Both requesting: DMA wins iff starve_cnt == STARVE_MAX, otherwise CPU wins.
- On grant: latch owner, we, addr and wdata into the registers that drive mem_*, and set gnt_dma.
- ISSUE: mem_en = 1 and mem_we = latched we, for one cycle. Go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles, counted by a lat counter.
  - In the last WAIT cycle, capture mem_rdata into the owner's rdata register, for reads only.
  - The other port's rdata is never modified.
  - Go to DONE.
- DONE: pulse the owner's rdy for one cycle. Writes also pulse rdy. Go to IDLE.
- Request rules:
  - A port's req seen in any IDLE cycle is treated as a new access.
  - A requester must drop req, or present its next access, in the cycle after its rdy.
  - req/we/addr/wdata must stay stable from assertion to rdy. The arbiter uses only the values latched at grant.
- starve_cnt:
  - Increments every cycle in which dma_req = 1 and DMA is not the granted owner.
  - Saturates at STARVE_MAX.
  - Clears to 0 in the cycle DMA is granted.
- A request arriving during ISSUE/WAIT/DONE waits. It is evaluated in the next IDLE.
- Arithmetic: lat counter is clog2(MEM_LAT+1) bits and starve_cnt is clog2(STARVE_MAX+1) bits, both unsigned, no wrap.

## Timing
- Reset (rst low, asynchronous): state IDLE. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata, cpu_rdy, dma_rdy, gnt_dma, busy. Counters 0.
- Reset mid-access: the access is aborted, no rdy is issued, late mem_rdata is ignored. The first IDLE decision happens on the first rising edge after deassertion.
- Access latency, with req seen in IDLE at cycle 0:
  - mem_en in cycle 1.
  - mem_rdata sampled in cycle 1+MEM_LAT.
  - rdy and valid rdata in cycle 2+MEM_LAT. rdata holds until that port's next read completes.
- Throughput: one access per MEM_LAT+3 cycles; the next IDLE is cycle 3+MEM_LAT.
- At most one of cpu_rdy and dma_rdy is high in any cycle. mem_en is never high outside ISSUE.

## Test plan
- CPU read alone, MEM_LAT=2, cpu_addr=0x3000, memory model returns 0x1234 -> mem_en in cycle 1 only with mem_addr=0x3000, mem_we=0; cpu_rdy in cycle 4 with cpu_rdata=0x1234; dma_rdy stays 0.
- DMA write alone, dma_addr=0xFE00, dma_wdata=0xBEEF -> one cycle with mem_en=mem_we=1, mem_addr=0xFE00, mem_wdata=0xBEEF; gnt_dma=1 from cycle 1 through cycle 4; dma_rdy in cycle 4; cpu_rdata unchanged.
- CPU and DMA requesting in cycle 0, starve_cnt=0 -> CPU mem_en in cycle 1 and cpu_rdy in cycle 4; DMA granted in the IDLE of cycle 5, mem_en in cycle 6, dma_rdy in cycle 9.
- CPU re-requests back-to-back, DMA holds req from cycle 0, STARVE_MAX=8 -> CPU wins the IDLE of cycle 5 (starve_cnt=5); DMA wins the IDLE of cycle 10 (starve_cnt=8); starve_cnt=0 in cycle 11.
- rst low in cycle 2 (WAIT) of a CPU read -> all outputs 0 immediately; no cpu_rdy for that access; after release, a new cpu_req completes normally in MEM_LAT+3 cycles.
- MEM_LAT=1 -> cpu_rdy in cycle 3; mem_rdata sampled in cycle 2.
